// File: rtl/text_pixel_fetch_pkg.sv
// Shared text-mode geometry for the pixel fetch pipeline and the colour stage.
package text_pkg;
    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int FETCH_LAT = 3;
    localparam int H_ACTIVE  = CHAR_W * TEXT_COLS;
    localparam int V_ACTIVE  = CHAR_H * TEXT_ROWS;

    function automatic logic [11:0] char_index(input logic [4:0] row, input logic [6:0] column);
        return 12'(row) * 12'(TEXT_COLS) + 12'(column);
    endfunction
endpackage

// File: rtl/text_pixel_fetch_if.sv
// Pixel fetch bus: timing coordinates, char/font memory ports and aligned outputs.
// Defining CURSOR_BLINK_EN adds the cursor position inputs.
interface text_pixel_fetch_if;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        valid_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] cram_addr;
    logic [7:0]  cram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        current_bit;
    logic [7:0]  col;
    logic        valid_out;
    logic        hsync_out;
    logic        vsync_out;
`ifdef CURSOR_BLINK_EN
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    modport master (output h_addr, v_addr, valid_in, hsync_in, vsync_in, cram_data, font_data,
                    cursor_row, cursor_col,
                    input  cram_addr, font_addr, current_bit, col, valid_out, hsync_out, vsync_out);
    modport slave  (input  h_addr, v_addr, valid_in, hsync_in, vsync_in, cram_data, font_data,
                    cursor_row, cursor_col,
                    output cram_addr, font_addr, current_bit, col, valid_out, hsync_out, vsync_out);
`else
    modport master (output h_addr, v_addr, valid_in, hsync_in, vsync_in, cram_data, font_data,
                    input  cram_addr, font_addr, current_bit, col, valid_out, hsync_out, vsync_out);
    modport slave  (input  h_addr, v_addr, valid_in, hsync_in, vsync_in, cram_data, font_data,
                    output cram_addr, font_addr, current_bit, col, valid_out, hsync_out, vsync_out);
`endif
endinterface

// File: rtl/text_pixel_fetch_pipe_delay.sv
// Fixed-depth shift register with a per-bit reset pattern, used for sideband alignment.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per clock; reset loads the idle pattern into every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= RESET_VAL;
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end
    end

    assign dout = stage_r[DEPTH-1];
endmodule

// File: rtl/text_pixel_fetch.sv
// Text-mode pixel fetch: char RAM -> font ROM -> foreground bit, 3-cycle aligned pipeline.
// Optional feature macro: CURSOR_BLINK_EN (blinking underline cursor).
module text_pixel_fetch
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    text_pixel_fetch_if.slave bus
);
    localparam int              SB_W     = 14;
    // Sideband layout {valid, hsync, vsync, hit, col[6:0], x_bit[2:0]}; syncs idle high.
    localparam logic [SB_W-1:0] SB_RESET = 14'h1800;

    logic             in_range_s;
    logic             valid0_s;
    logic             hit0_s;
    logic [11:0]      cram_addr_s;
    logic [SB_W-1:0]  side0_s;
    logic [SB_W-1:0]  side2_s;
    logic [3:0]       glyph_row1_s;
    logic             valid2_s;
    logic             hsync2_s;
    logic             vsync2_s;
    logic             hit2_s;
    logic [6:0]       col2_s;
    logic [2:0]       x_bit2_s;
    logic             current_bit_r;
    logic [7:0]       col_r;
    logic             valid_out_r;
    logic             hsync_out_r;
    logic             vsync_out_r;

    // Off-screen coordinates never count as valid and read a harmless address.
    always_comb begin
        in_range_s = (int'(bus.h_addr) < H_ACTIVE) && (int'(bus.v_addr) < V_ACTIVE);
        valid0_s   = bus.valid_in && in_range_s;
        if (in_range_s) begin
            cram_addr_s = char_index(bus.v_addr[8:4], bus.h_addr[9:3]);
        end else begin
            cram_addr_s = 12'd0;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic       vsync_prev_r;
    logic [4:0] frame_cnt_r;

    // Count vsync falling edges; bit 4 is the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_r <= 1'b1;
            frame_cnt_r  <= 5'd0;
        end else begin
            vsync_prev_r <= bus.vsync_in;
            if (vsync_prev_r && !bus.vsync_in) begin
                frame_cnt_r <= frame_cnt_r + 5'd1;
            end
        end
    end

    assign hit0_s = valid0_s && frame_cnt_r[4] &&
                    (bus.v_addr[8:4] == bus.cursor_row) &&
                    (bus.h_addr[9:3] == bus.cursor_col) &&
                    (bus.v_addr[3:0] >= 4'd14);
`else
    assign hit0_s = 1'b0;
`endif

    assign side0_s = {valid0_s, bus.hsync_in, bus.vsync_in, hit0_s, bus.h_addr[9:3], bus.h_addr[2:0]};
    assign {valid2_s, hsync2_s, vsync2_s, hit2_s, col2_s, x_bit2_s} = side2_s;

    // The last of the FETCH_LAT stages is the output register below.
    pipe_delay #(.WIDTH(SB_W), .DEPTH(FETCH_LAT - 1), .RESET_VAL(SB_RESET)) u_side (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (side0_s),
        .dout  (side2_s)
    );

    pipe_delay #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) u_glyph (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.v_addr[3:0]),
        .dout  (glyph_row1_s)
    );

    // Output stage: pick the glyph bit (MSB is leftmost) and blank invalid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_bit_r <= 1'b0;
            col_r         <= 8'd0;
            valid_out_r   <= 1'b0;
            hsync_out_r   <= 1'b1;
            vsync_out_r   <= 1'b1;
        end else begin
            if (valid2_s) begin
                current_bit_r <= bus.font_data[3'd7 - x_bit2_s] | hit2_s;
                col_r         <= {1'b0, col2_s};
            end else begin
                current_bit_r <= 1'b0;
                col_r         <= 8'd0;
            end
            valid_out_r <= valid2_s;
            hsync_out_r <= hsync2_s;
            vsync_out_r <= vsync2_s;
        end
    end

    assign bus.cram_addr   = cram_addr_s;
    assign bus.font_addr   = {bus.cram_data, glyph_row1_s};
    assign bus.current_bit = current_bit_r;
    assign bus.col         = col_r;
    assign bus.valid_out   = valid_out_r;
    assign bus.hsync_out   = hsync_out_r;
    assign bus.vsync_out   = vsync_out_r;
endmodule

// File: tb/tb_text_pixel_fetch.sv
// Scoreboard bench for text_pixel_fetch: per-pixel expectations stamped with their drive cycle.
module tb_text_pixel_fetch;
    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    text_pixel_fetch_if tif();
    text_pixel_fetch dut (.clk(clk), .rst_n(rst_n), .bus(tif.slave));

    typedef struct {
        int         stamp;
        logic       cb;
        logic [7:0] col;
        logic       vld;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [4:0] m_cnt = 5'd0;
    logic       m_vs_prev = 1'b1;
    logic [7:0] cram_mem [0:4095];
    logic [7:0] font_mem [0:4095];

    // Synchronous memory models with one cycle of read latency.
    always @(posedge clk) begin
        tif.cram_data <= cram_mem[tif.cram_addr];
        tif.font_data <= font_mem[tif.font_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a pixel driven in cycle k is due at the negedge of cycle k+3.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].stamp < cyc - 3) begin
            errors++;
            checks++;
            $display("FAIL sb_stale: entry stamp %0d not seen by cycle %0d", sb[0].stamp, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].stamp == cyc - 3) begin
            mon_e = sb.pop_front();
            checks++;
            if ({tif.current_bit, tif.col, tif.valid_out, tif.hsync_out, tif.vsync_out} !==
                {mon_e.cb, mon_e.col, mon_e.vld, mon_e.hs, mon_e.vs}) begin
                errors++;
                $display("FAIL pipe_out stamp %0d: got bit=%b col=%0d v=%b hs=%b vs=%b want bit=%b col=%0d v=%b hs=%b vs=%b",
                         mon_e.stamp, tif.current_bit, tif.col, tif.valid_out, tif.hsync_out, tif.vsync_out,
                         mon_e.cb, mon_e.col, mon_e.vld, mon_e.hs, mon_e.vs);
            end
        end
    end

    task automatic drive_now(input logic [9:0] h, input logic [9:0] v, input logic vld,
                             input logic hs, input logic vs);
        exp_t        e;
        logic        ok;
        logic [11:0] idx;
        logic [7:0]  ch;
        logic        hit;
        tif.h_addr   = h;
        tif.v_addr   = v;
        tif.valid_in = vld;
        tif.hsync_in = hs;
        tif.vsync_in = vs;
        ok  = vld && (h < 10'd640) && (v < 10'd480);
        idx = 12'(v / 10'd16) * 12'd80 + 12'(h / 10'd8);
        ch  = cram_mem[idx];
        hit = 1'b0;
`ifdef CURSOR_BLINK_EN
        hit = m_cnt[4] && (v / 10'd16 == 10'(tif.cursor_row)) && (h / 10'd8 == 10'(tif.cursor_col)) &&
              (v % 10'd16 >= 10'd14);
        if (m_vs_prev && !vs) m_cnt = m_cnt + 5'd1;
        m_vs_prev = vs;
`endif
        e.stamp = cyc;
        e.vld   = ok;
        e.hs    = hs;
        e.vs    = vs;
        e.cb    = ok ? (font_mem[{ch, v[3:0]}][3'd7 - h[2:0]] | hit) : 1'b0;
        e.col   = ok ? 8'(h / 10'd8) : 8'd0;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic vld,
                         input logic hs, input logic vs);
        @(posedge clk);
        #1;
        drive_now(h, v, vld, hs, vs);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        drive_now(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        sb.delete();
        m_cnt     = 5'd0;
        m_vs_prev = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if ({tif.current_bit, tif.col, tif.valid_out, tif.hsync_out, tif.vsync_out} !== {1'b0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reset_values: got %b_%h_%b%b%b want 0_00_011", tif.current_bit, tif.col,
                         tif.valid_out, tif.hsync_out, tif.vsync_out);
            end
        end
    endtask

    // Release reset while presenting a pixel; the two outputs before it hold reset values.
    task automatic release_with(input logic [9:0] h, input logic [9:0] v, input logic vld);
        exp_t r;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r.cb = 1'b0; r.col = 8'd0; r.vld = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
        r.stamp = cyc - 2;
        sb.push_back(r);
        r.stamp = cyc - 1;
        sb.push_back(r);
        drive_now(h, v, vld, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        do_reset(3);
        release_with(10'd0, 10'd0, 1'b0);
        repeat (3) drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_char_a();
        for (int h = 0; h < 8; h++) begin
            drive(10'(h), 10'd0, 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (tif.cram_addr !== 12'd0) begin
                errors++;
                $display("FAIL char_a_cram h=%0d: got %0d want 0", h, tif.cram_addr);
            end
            if (h > 0) begin
                checks++;
                if (tif.font_addr !== 12'h410) begin
                    errors++;
                    $display("FAIL char_a_font h=%0d: got %h want 410", h, tif.font_addr);
                end
            end
        end
    endtask

    task automatic test_corner();
        drive(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (tif.cram_addr !== 12'd2399) begin
            errors++;
            $display("FAIL corner_cram: got %0d want 2399", tif.cram_addr);
        end
        drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++;
        if (tif.font_addr !== 12'h42F) begin
            errors++;
            $display("FAIL corner_font: got %h want 42f", tif.font_addr);
        end
    endtask

    task automatic test_invalid();
        for (int i = 0; i < 8; i++) begin
            drive(10'(i), 10'd0, 1'b0, (i == 2 || i == 3) ? 1'b0 : 1'b1, (i == 5) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic test_out_of_range();
        logic [9:0] hs_tab [3];
        logic [9:0] vs_tab [3];
        hs_tab[0] = 10'd640;  vs_tab[0] = 10'd0;
        hs_tab[1] = 10'd5;    vs_tab[1] = 10'd480;
        hs_tab[2] = 10'd1023; vs_tab[2] = 10'd1023;
        for (int i = 0; i < 3; i++) begin
            drive(hs_tab[i], vs_tab[i], 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (tif.cram_addr !== 12'd0) begin
                errors++;
                $display("FAIL oor_cram h=%0d v=%0d: got %0d want 0", hs_tab[i], vs_tab[i], tif.cram_addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] h;
        logic [9:0] v;
        for (int i = 0; i < 24; i++) drive(10'(i), 10'd37, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            h = 10'($urandom_range(0, 639));
            v = 10'($urandom_range(0, 479));
            drive(h, v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
            #1;
            checks++;
            if (int'(tif.cram_addr) != (int'(v) / 16) * 80 + int'(h) / 8) begin
                errors++;
                $display("FAIL b2b_cram h=%0d v=%0d: got %0d want %0d", h, v, tif.cram_addr,
                         (int'(v) / 16) * 80 + int'(h) / 8);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 40; i < 46; i++) drive(10'(i), 10'd100, 1'b1, 1'b1, 1'b1);
        do_reset(2);
        release_with(10'd48, 10'd100, 1'b1);
        for (int i = 49; i < 53; i++) drive(10'(i), 10'd100, 1'b1, 1'b1, 1'b1);
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_cursor();
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 40 && m_cnt[4] == phase[0]; n++) begin
                drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
                drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
            end
            for (int h = 0; h < 10; h++) drive(10'(h), 10'd14, 1'b1, 1'b1, 1'b1);
            for (int h = 0; h < 8; h++) drive(10'(h), 10'd15, 1'b1, 1'b1, 1'b1);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            cram_mem[i] = 8'((i * 13 + 5) % 256);
            font_mem[i] = 8'(((i * 37 + 11) ^ (i / 16)) % 256);
        end
        cram_mem[0]     = 8'h41;
        cram_mem[2399]  = 8'h42;
        font_mem[12'h410] = 8'b0001_1000;
        font_mem[12'h41E] = 8'h00;
        font_mem[12'h41F] = 8'h00;
        font_mem[12'h42F] = 8'hA5;
`ifdef CURSOR_BLINK_EN
        tif.cursor_row = 5'd0;
        tif.cursor_col = 7'd0;
`endif
        tif.h_addr = 10'd0; tif.v_addr = 10'd0; tif.valid_in = 1'b0;
        tif.hsync_in = 1'b1; tif.vsync_in = 1'b1;

        test_reset();
        test_char_a();
        test_corner();
        test_invalid();
        test_out_of_range();
        test_back_to_back();
        test_mid_reset();
`ifdef CURSOR_BLINK_EN
        test_cursor();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
